// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch squash and
// saturating stall/flush performance counters.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [8:0]        id_ctrl,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [8:0]        ex_ctrl,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MEMREAD_BIT = 7;

  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        ex_rs_q, ex_rs_d;
  logic [4:0]        ex_rt_q, ex_rt_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [8:0]        ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hz;
  logic              src_match;

  always_comb begin
    src_match = (id_uses_rs & (id_rs == ex_rt_q)) | (id_uses_rt & (id_rt == ex_rt_q));
    hz        = ex_valid_q & ex_ctrl_q[MEMREAD_BIT] & (ex_rt_q != 5'd0) & id_valid & src_match;
  end

  // Flush wins so the PC is free to take the branch target.
  assign stall      = hz & ~flush;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  always_comb begin
    // Bubble by default; counters hold.
    ex_valid_d   = 1'b0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_rd_d      = '0;
    ex_rs_data_d = '0;
    ex_rt_data_d = '0;
    ex_imm_d     = '0;
    ex_ctrl_d    = '0;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush) begin
      if (id_valid && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall) begin
      if (stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      ex_valid_d   = id_valid;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_rd;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm;
      ex_ctrl_d    = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection and branch flush.
- Captures decoded operands and control from ID each cycle and presents the EX-stage fields (rs, rt, rd, RegWrite, operand data) that the EX-stage forwarding unit consumes.
- On a load-use hazard it stalls PC and IF/ID and inserts one bubble. On a taken branch it squashes the ID instruction.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- DATA_W, 32, width of register operands and immediate
- CNT_W, 16, width of stall/flush performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  source register 1 number
- id_rt  in  5  source register 2 number
- id_rd  in  5  destination register number (R-type)
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_rs_data  in  DATA_W  register file read data 1
- id_rt_data  in  DATA_W  register file read data 2
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]}
- flush  in  1  taken branch/jump resolved; squash the ID instruction
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_rd  out  5 each  registered register numbers
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands
- ex_ctrl  out  9  registered control, same packing as id_ctrl
- stall  out  1  combinational load-use hazard indication
- pc_write  out  1  PC update enable (~stall)
- ifid_write  out  1  IF/ID update enable (~stall)
- stall_cnt  out  CNT_W  bubbles inserted by load-use stalls, saturating
- flush_cnt  out  CNT_W  instructions squashed by flush, saturating

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including ex_valid, all ex_* fields, and both counters. stall=0, pc_write=1, ifid_write=1 while in reset.
- Hazard condition, combinational from the current EX contents and ID inputs:
  - hz = ex_valid & ex_ctrl.MemRead & ex_rt!=0 & id_valid & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt))
  - stall = hz & ~flush. Flush takes priority so the PC can take the branch target.
- Register update, per rising edge with priority flush > stall > normal:
  - flush=1: load bubble. flush_cnt increments by 1 if id_valid=1, saturating at all-ones.
  - stall=1: load bubble. stall_cnt increments by 1, saturating.
  - otherwise: load every id_* field. ex_valid <= id_valid.
- Bubble definition:
  - ex_valid=0, ex_ctrl=0, ex_rs=ex_rt=ex_rd=0.
  - Data fields are 0.
  - Zeroed register numbers ensure the forwarding unit never matches on a bubble.
- Stall duration:
  - The bubble clears MemRead, so hz drops the following cycle.
  - A single load-use pair stalls exactly 1 cycle. Back-to-back dependent loads each stall 1 cycle.
- Latency: 1 cycle from id_* to ex_*. stall/pc_write/ifid_write have zero latency (combinational).
- ex_rt==0 never hazards, even for a load targeting $0.
- id_valid=0 (an existing ID bubble) never hazards and never counts as a flush.
- Reset asserted mid-stall: outputs clear immediately. After release, the next edge behaves as normal load.
- Counters hold at 2^CNT_W-1 once saturated and never wrap.

Test Plan:
1. Reset → all ex_* and both counters are 0, pc_write=1. After release, feed add $3,$1,$2 (rs=1, rt=2, rd=3, RegWrite) → next cycle ex_rs=1, ex_rt=2, ex_rd=3, ex_valid=1, stall=0.
2. Load-use: EX holds lw $5 (MemRead, ex_rt=5), ID presents add using rs=5 → stall=1 and pc_write=ifid_write=0 in the same cycle. Next edge: ex_valid=0, ex_ctrl=0, stall_cnt=1. Following cycle stall=0 and the add enters EX.
3. Non-hazards: lw $0 then a use of $0 → no stall. lw $5 then an instruction with id_uses_rt=0 and id_rt=5 → no stall. lw $5 then a use of $6 → no stall.
4. Flush with a concurrent hazard: lw $5 in EX, dependent instruction in ID, flush=1 → stall=0, pc_write=1. Next edge inserts a bubble, flush_cnt=1, stall_cnt unchanged.
5. Saturation: force 65536 stalls (CNT_W=16) → stall_cnt=16'hFFFF and it stays there on the next stall.
6. Assert rst_n=0 asynchronously between edges while stall=1 → outputs zero immediately with no clock edge. After deassert, normal capture resumes.
